// File: rtl/tama_pkg.sv
// Shared types for the pet-game blocks: scheduler state encoding and event codes.
package tama_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_LOAD    = 2'd1,
    SCHED_COUNT   = 2'd2,
    SCHED_REQUEST = 2'd3
  } sched_state_t;

  typedef logic [1:0] event_t;

  localparam event_t EVT_HUNGER = 2'd0;
  localparam event_t EVT_BORED  = 2'd1;
  localparam event_t EVT_SICK   = 2'd2;
  localparam event_t EVT_POOP   = 2'd3;

endpackage

// File: rtl/random_event_scheduler.sv
// Draws a random tick interval, counts it down, then raises a pet event request
// that is held until acknowledged or until it times out.
module random_event_scheduler
  import tama_pkg::*;
#(
  parameter int MIN_INTERVAL = 16,
  parameter int RANGE_BITS   = 5,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic       in_clk,
  input  logic       in_n_rst,
  input  logic       in_enable,
  input  logic       in_tick,
  input  logic [7:0] in_random,
  input  logic       in_ack,
  output logic       out_req,
  output logic [1:0] out_event,
  output logic [7:0] out_countdown,
  output logic       out_missed,
  output logic       out_busy,
  output logic [1:0] out_state
);

  localparam logic [1:0] ST_IDLE    = SCHED_IDLE;
  localparam logic [1:0] ST_LOAD    = SCHED_LOAD;
  localparam logic [1:0] ST_COUNT   = SCHED_COUNT;
  localparam logic [1:0] ST_REQUEST = SCHED_REQUEST;

  localparam logic [7:0] MIN_V     = 8'(MIN_INTERVAL);
  localparam logic [8:0] TIMEOUT_V = 9'(ACK_TIMEOUT);

  // Handshake: out_req rises with a stable out_event and stays up until in_ack
  // is sampled high (dropped on the following edge) or the timeout expires.

  logic [1:0] state;
  logic [7:0] timeout_cnt;
  logic [7:0] interval;
  logic [8:0] timeout_next;
  logic [1:0] after_request;
  logic       unused_random;

  assign interval      = MIN_V + {{(8 - RANGE_BITS){1'b0}}, in_random[RANGE_BITS-1:0]};
  assign timeout_next  = {1'b0, timeout_cnt} + 9'd1;
  assign after_request = in_enable ? ST_LOAD : ST_IDLE;
  assign unused_random = &{1'b0, in_random};

  assign out_busy  = (state != ST_IDLE);
  assign out_state = state;

  always_ff @(posedge in_clk or negedge in_n_rst) begin
    if (!in_n_rst) begin
      state         <= ST_IDLE;
      out_req       <= 1'b0;
      out_event     <= EVT_HUNGER;
      out_countdown <= 8'd0;
      out_missed    <= 1'b0;
      timeout_cnt   <= 8'd0;
    end else begin
      out_missed <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_enable) state <= ST_LOAD;
        end

        ST_LOAD: begin
          // Ticks arriving here are dropped; disabling freezes the countdown.
          if (!in_enable) begin
            state <= ST_IDLE;
          end else begin
            out_countdown <= interval;
            state         <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (!in_enable) begin
            state <= ST_IDLE;
          end else if (in_tick) begin
            if (out_countdown <= 8'd1) begin
              out_countdown <= 8'd0;
              out_req       <= 1'b1;
              out_event     <= in_random[7:6];
              timeout_cnt   <= 8'd0;
              state         <= ST_REQUEST;
            end else begin
              out_countdown <= out_countdown - 8'd1;
            end
          end
        end

        ST_REQUEST: begin
          // Ack beats a coincident timeout tick, so no miss is flagged then.
          if (in_ack) begin
            out_req <= 1'b0;
            state   <= after_request;
          end else if (in_tick) begin
            if (timeout_next >= TIMEOUT_V) begin
              out_req    <= 1'b0;
              out_missed <= 1'b1;
              state      <= after_request;
            end
            timeout_cnt <= timeout_next[7:0];
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/random_event_scheduler.md
Name: random_event_scheduler

Overview:
Consumer of the 8-bit LFSR random generator output. It schedules pseudo-random pet events: hunger, boredom, sickness and poop. It draws a random wait interval in game ticks, counts it down, then issues an event request to the pet-state controller over a req/ack handshake. If the controller does not acknowledge in time, the request times out.

Parameters:
MIN_INTERVAL, 16, minimum ticks between events (1..255).
RANGE_BITS, 5, random bits added to MIN_INTERVAL (1..7); MIN_INTERVAL + 2^RANGE_BITS - 1 must be <= 255.
ACK_TIMEOUT, 8, ticks a request may stay unacknowledged (1..255).

Ports:
in_clk  input  1  system clock
in_n_rst  input  1  asynchronous active-low reset
in_enable  input  1  scheduler run enable (level)
in_tick  input  1  game time base, one-cycle pulse
in_random  input  8  current LFSR value from the random generator
in_ack  input  1  event accepted by pet-state controller
out_req  output  1  event request, held until ack or timeout
out_event  output  2  event code, valid while out_req=1
out_countdown  output  8  ticks remaining before next request
out_missed  output  1  one-cycle pulse on request timeout
out_busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, in_n_rst=0): state IDLE, out_req=0, out_event=0, out_countdown=0, out_missed=0, out_busy=0, timeout counter=0.
- FSM states: IDLE, LOAD, COUNT, REQUEST.
- IDLE: if in_enable=1, go to LOAD on the next clock.
- LOAD (exactly one cycle):
  - out_countdown <= MIN_INTERVAL + in_random[RANGE_BITS-1:0], zero-extended 8-bit add, no overflow by parameter rule.
  - Next state is COUNT. Any in_tick during LOAD is ignored.
- COUNT:
  - On in_tick, out_countdown decrements by 1.
  - When a tick occurs with out_countdown==1: countdown becomes 0, state becomes REQUEST, out_req=1, out_event <= in_random[7:6] sampled that cycle, timeout counter cleared. All of these take effect on the same clock edge.
- REQUEST:
  - out_req and out_event stay stable.
  - in_ack=1 sampled: out_req=0 on the next edge, state goes to LOAD.
  - Each in_tick increments the timeout counter. When it reaches ACK_TIMEOUT: out_req=0, out_missed=1 for one cycle, state goes to LOAD.
  - If ack and the timeout tick occur in the same cycle, ack wins and out_missed stays 0.
- in_ack outside REQUEST is ignored.
- in_enable=0:
  - In LOAD or COUNT: go to IDLE next cycle; out_countdown holds its value.
  - In REQUEST: the handshake completes (ack or timeout), then the FSM goes to IDLE instead of LOAD.
- Re-enable from IDLE always reloads through LOAD, so a fresh interval is drawn.
- in_random=0 (unseeded LFSR): interval = MIN_INTERVAL. No special handling.
- Latency: 1 clock from the final tick to out_req=1; 1 clock from in_ack to out_req=0.
- The minimum spacing between requests is MIN_INTERVAL ticks plus 2 clocks.

Decomposition:
- Shared package tama_pkg holds:
  - state enum SCHED_IDLE/LOAD/COUNT/REQUEST.
  - event codes EVT_HUNGER=2'd0, EVT_BORED=2'd1, EVT_SICK=2'd2, EVT_POOP=2'd3.
  - typedef event_t (2-bit).
- No sub-module. The FSM, countdown and timeout counter are one module of roughly 150-200 lines.

Test Plan:
- Reset mid-COUNT (countdown=9): assert in_n_rst=0 -> all outputs 0 immediately, without waiting for a clock edge; after release with in_enable=1, LOAD occurs again.
- Defaults, in_random=8'hA3, enable, then ticks:
  - LOAD gives out_countdown=16+3=19.
  - After 19 ticks, out_req=1 one clock later.
  - With in_random=8'h4E at that edge, out_event=2'd1.
- Ack on the 3rd cycle of REQUEST -> out_req=0 on the next edge, out_missed=0, then LOAD with the new in_random, out_busy=1 throughout.
- Hold in_ack=0 for 8 ticks in REQUEST -> out_req falls and out_missed=1 for exactly one cycle, followed by LOAD.
- in_ack=1 coincides with the 8th timeout tick -> out_missed=0; in_ack while in COUNT has no effect and the countdown is unchanged.
- Drop in_enable during REQUEST, then ack -> IDLE with out_busy=0; in_random=8'h00 on re-enable -> out_countdown=16.
